// File: rtl/mem_access_initiator.sv
// mem_access_initiator
//   Requester-side controller for the memory-cell access FSM. Accepts host
//   read/write commands over a ready/valid handshake, drives op/selFSM to the
//   access FSM, presents registered address/write data to the cell array,
//   waits for a matching fsm_valid, captures read data and returns a one-cycle
//   completion. A watchdog aborts commands the FSM never completes.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready               host command handshake
//   cmd_we, cmd_addr, cmd_wdata       command fields (1 = write)
//   rsp_valid, rsp_err, rsp_rdata     completion pulse, abort flag, read data
//   op, selFSM                        controls to the access FSM
//   mem_addr, mem_wdata               registered address/data to cell array
//   fsm_rw, fsm_valid                 status from the access FSM
//   mem_rdata                         cell array read data
module mem_access_initiator #(
   parameter int unsigned AW      = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CW      = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [DW-1:0] rsp_rdata,
   output logic          op,
   output logic          selFSM,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          fsm_rw,
   input  logic          fsm_valid,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RELEASE
   } state_t;

   state_t        state, state_next;
   logic          we_q, we_next;
   logic [CW-1:0] wd, wd_next;
   logic          cmd_ready_next, op_next, sel_next;
   logic          rsp_valid_next, rsp_err_next;
   logic [DW-1:0] rsp_rdata_next;
   logic [AW-1:0] addr_next;
   logic [DW-1:0] wdata_next;
   logic          done;

   // Completion only counts once the FSM reports the direction we asked for.
   assign done = fsm_valid && (fsm_rw == we_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         wd        <= '0;
         cmd_ready <= 1'b0;
         op        <= 1'b0;
         selFSM    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_next;
         we_q      <= we_next;
         wd        <= wd_next;
         cmd_ready <= cmd_ready_next;
         op        <= op_next;
         selFSM    <= sel_next;
         rsp_valid <= rsp_valid_next;
         rsp_err   <= rsp_err_next;
         rsp_rdata <= rsp_rdata_next;
         mem_addr  <= addr_next;
         mem_wdata <= wdata_next;
      end
   end

   always_comb begin
      state_next     = state;
      we_next        = we_q;
      wd_next        = wd;
      rsp_valid_next = 1'b0;
      rsp_err_next   = 1'b0;
      rsp_rdata_next = rsp_rdata;
      addr_next      = mem_addr;
      wdata_next     = mem_wdata;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_next = ISSUE;
               we_next    = cmd_we;
               addr_next  = cmd_addr;
               wdata_next = cmd_wdata;
            end
         end
         ISSUE: begin
            wd_next    = '0;
            state_next = WAIT;
         end
         WAIT: begin
            wd_next = wd + CW'(1);
            // Completion wins over a timeout landing in the same cycle.
            if (done) begin
               state_next     = RELEASE;
               rsp_valid_next = 1'b1;
               if (!we_q) begin
                  rsp_rdata_next = mem_rdata;
               end
            end else if (wd == CW'(TIMEOUT - 1)) begin
               state_next     = RELEASE;
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b1;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Registered outputs are decoded from the state being entered, so they
      // line up with that state's cycle. A write holds op for ISSUE and the
      // first WAIT cycle only (the cycle that follows ISSUE).
      cmd_ready_next = (state_next == IDLE);
      sel_next       = (state_next == ISSUE) || (state_next == WAIT);
      op_next        = ((state_next == ISSUE) && we_next) ||
                       ((state == ISSUE) && we_q);
   end

endmodule

// File: tb/tb_mem_access_initiator.sv
module tb_mem_access_initiator;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          op;
   logic          selFSM;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          fsm_rw;
   logic          fsm_valid;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_access_initiator #(
      .AW(AW),
      .DW(DW),
      .TIMEOUT(15),
      .CW(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we(cmd_we),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata),
      .op(op),
      .selFSM(selFSM),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .fsm_rw(fsm_rw),
      .fsm_valid(fsm_valid),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      fsm_rw    = 1'b0;
      fsm_valid = 1'b0;
      mem_rdata = '0;

      // Power-on reset
      #2 rst_n = 1'b0;
      #1;
      chk("rst_op", op, 0);
      chk("rst_sel", selFSM, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("ready_before_edge", cmd_ready, 0);
      tick();
      chk("ready_after_release", cmd_ready, 1);

      // Write A5 to address 3; FSM reports valid in the second WAIT cycle
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'hA5;
      tick(); // ISSUE
      cmd_valid = 1'b0; cmd_addr = 4'h0; cmd_wdata = 8'h00;
      chk("wr_issue_op", op, 1);
      chk("wr_issue_sel", selFSM, 1);
      chk("wr_issue_ready", cmd_ready, 0);
      chk("wr_addr", mem_addr, 4'h3);
      chk("wr_wdata", mem_wdata, 8'hA5);
      tick(); // WAIT 1
      chk("wr_wait1_op", op, 1);
      chk("wr_wait1_sel", selFSM, 1);
      tick(); // WAIT 2
      chk("wr_wait2_op", op, 0);
      chk("wr_wait2_sel", selFSM, 1);
      chk("wr_wait2_rsp", rsp_valid, 0);
      fsm_valid = 1'b1; fsm_rw = 1'b1;
      tick(); // RELEASE
      fsm_valid = 1'b0; fsm_rw = 1'b0;
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_err", rsp_err, 0);
      chk("wr_rel_sel", selFSM, 0);
      chk("wr_rel_op", op, 0);
      chk("wr_rel_addr", mem_addr, 4'h3);
      chk("wr_rel_wdata", mem_wdata, 8'hA5);
      tick(); // IDLE
      chk("wr_rsp_pulse", rsp_valid, 0);
      chk("wr_idle_ready", cmd_ready, 1);

      // Read from 7 with a direction-mismatched valid first
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h7; cmd_wdata = 8'hFF;
      tick(); // ISSUE
      cmd_valid = 1'b0;
      chk("rd_issue_op", op, 0);
      chk("rd_issue_sel", selFSM, 1);
      chk("rd_addr", mem_addr, 4'h7);
      tick(); // WAIT 1
      chk("rd_wait1_op", op, 0);
      fsm_valid = 1'b1; fsm_rw = 1'b1; mem_rdata = 8'hEE;
      tick(); // WAIT 2, mismatch ignored
      chk("mm_rsp", rsp_valid, 0);
      chk("mm_sel", selFSM, 1);
      chk("mm_op", op, 0);
      fsm_rw = 1'b0; mem_rdata = 8'h5A;
      tick(); // RELEASE
      fsm_valid = 1'b0; mem_rdata = 8'h00;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_err", rsp_err, 0);
      chk("rd_rdata", rsp_rdata, 8'h5A);
      chk("rd_rel_sel", selFSM, 0);
      tick(); // IDLE
      chk("rd_idle_ready", cmd_ready, 1);
      chk("rd_rdata_hold", rsp_rdata, 8'h5A);

      // Back-to-back write then read, cmd_valid held high
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11;
      tick(); // ISSUE (write)
      cmd_we = 1'b0; cmd_addr = 4'h2; cmd_wdata = 8'h22;
      chk("b2b_issue_ready", cmd_ready, 0);
      tick(); // WAIT 1
      chk("b2b_wr_op", op, 1);
      fsm_valid = 1'b1; fsm_rw = 1'b1;
      tick(); // RELEASE
      fsm_valid = 1'b0; fsm_rw = 1'b0;
      chk("b2b_rsp1", rsp_valid, 1);
      chk("b2b_rel_ready", cmd_ready, 0);
      chk("b2b_rel_addr", mem_addr, 4'h1);
      tick(); // IDLE, second command accepted at the end of this cycle
      chk("b2b_idle_ready", cmd_ready, 1);
      chk("b2b_idle_rsp", rsp_valid, 0);
      chk("b2b_idle_addr", mem_addr, 4'h1);
      tick(); // ISSUE (read)
      cmd_valid = 1'b0;
      chk("b2b_rd_addr", mem_addr, 4'h2);
      chk("b2b_rd_op", op, 0);
      chk("b2b_rd_sel", selFSM, 1);
      fsm_valid = 1'b1; fsm_rw = 1'b0; mem_rdata = 8'hC3;
      tick(); // WAIT 1: valid here is sampled at end of this cycle
      chk("b2b_wait_rsp", rsp_valid, 0);
      tick(); // RELEASE
      fsm_valid = 1'b0; mem_rdata = 8'h00;
      chk("b2b_rsp2", rsp_valid, 1);
      chk("b2b_rdata", rsp_rdata, 8'hC3);
      tick(); // IDLE
      chk("b2b_end_rsp", rsp_valid, 0);

      // Timeout: FSM never answers, abort after 15 WAIT cycles
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h9;
      tick(); // ISSUE
      cmd_valid = 1'b0;
      tick(); // WAIT 1
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("to_wait%0d_sel", i + 1), selFSM, 1);
         chk($sformatf("to_wait%0d_rsp", i + 1), rsp_valid, 0);
         tick();
      end
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rdata_kept", rsp_rdata, 8'hC3);
      chk("to_sel", selFSM, 0);
      tick(); // IDLE
      chk("to_end_rsp", rsp_valid, 0);
      chk("to_end_err", rsp_err, 0);
      chk("to_end_ready", cmd_ready, 1);

      // Completion in the 15th WAIT cycle beats the timeout
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'hA;
      tick(); // ISSUE
      cmd_valid = 1'b0;
      tick(); // WAIT 1
      for (int i = 0; i < 14; i++) tick();
      chk("edge_wait15_sel", selFSM, 1);
      fsm_valid = 1'b1; fsm_rw = 1'b0; mem_rdata = 8'h77;
      tick(); // RELEASE
      fsm_valid = 1'b0; mem_rdata = 8'h00;
      chk("edge_rsp_valid", rsp_valid, 1);
      chk("edge_rsp_err", rsp_err, 0);
      chk("edge_rdata", rsp_rdata, 8'h77);
      tick(); // IDLE

      // Asynchronous reset in the middle of a write command
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'hF; cmd_wdata = 8'h3C;
      tick(); // ISSUE
      cmd_valid = 1'b0;
      chk("ar_pre_op", op, 1);
      chk("ar_pre_sel", selFSM, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_op", op, 0);
      chk("ar_sel", selFSM, 0);
      chk("ar_rsp_valid", rsp_valid, 0);
      chk("ar_rdata", rsp_rdata, 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_ready", cmd_ready, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_post_ready", cmd_ready, 1);
      chk("ar_post_rsp", rsp_valid, 0);
      chk("ar_post_sel", selFSM, 0);
      tick();
      chk("ar_no_rsp", rsp_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Requester-side controller for the memory-cell access FSM (inputs op/selFSM; outputs rw/valid).
- Accepts read/write commands from a host over a ready/valid handshake and drives op/selFSM to the FSM.
- Presents address and write data to the cell array, waits for the FSM's valid, captures read data, and returns a completion.
- Includes a watchdog that aborts a command the FSM never completes.

Parameters:
- AW, 4, address width.
- DW, 8, data width.
- TIMEOUT, 15, cycles in WAIT without a matching valid before abort; must be ≥2 and < 2^CW.
- CW, 5, watchdog counter width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  target address.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  completion pulse, one cycle.
- rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort.
- rsp_rdata  out  DW  read data; held until the next read completion.
- op  out  1  to FSM: 1 = write, 0 = read/stable.
- selFSM  out  1  to FSM: 1 = access active, 0 = return to IDLE.
- mem_addr  out  AW  registered address to the cell array.
- mem_wdata  out  DW  registered write data to the cell array.
- fsm_rw  in  1  FSM rw: 1 = write in progress, 0 = read.
- fsm_valid  in  1  FSM valid: operation complete.
- mem_rdata  in  DW  cell array read data, sampled when a read completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; op=0, selFSM=0, cmd_ready=0 while rst_n=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0; watchdog=0.
  - cmd_ready rises the first cycle after rst_n deasserts.
  - Reset mid-command drops the command; no response is issued.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - cmd_ready=1, selFSM=0, op=0.
  - On cmd_valid&cmd_ready: latch we→we_q, cmd_addr→mem_addr, cmd_wdata→mem_wdata; go to ISSUE.
- ISSUE (1 cycle):
  - selFSM=1, op=we_q, cmd_ready=0, watchdog cleared; go to WAIT.
- WAIT:
  - selFSM=1.
  - op=we_q for a write. A write has op=1 for exactly ISSUE plus the first WAIT cycle, then op=0; the FSM then passes WRITE→STABLE.
  - op=0 for a read throughout.
  - The watchdog increments each WAIT cycle.
  - Completion is fsm_valid=1 with fsm_rw==we_q. On completion:
    - for a read, capture mem_rdata→rsp_rdata;
    - assert rsp_valid=1, rsp_err=0 in the next cycle;
    - go to RELEASE.
  - fsm_valid with mismatched fsm_rw is ignored (FSM still transitioning).
  - If the watchdog reaches TIMEOUT before completion: rsp_valid=1, rsp_err=1, rsp_rdata unchanged; go to RELEASE.
  - A completion and the timeout in the same cycle count as success.
- RELEASE (1 cycle):
  - selFSM=0, op=0, returning the FSM to IDLE; go to IDLE.
- Latency: command accept to rsp_valid = 2 + (cycles to matching fsm_valid). Minimum accept-to-accept spacing is 4 cycles.
- Outputs are registered; rsp_valid is high for exactly one cycle.
- cmd_* is ignored when cmd_ready=0; the host must hold cmd_valid until accepted.
- Back-to-back: a command presented during RELEASE is accepted in the following IDLE cycle.
- mem_addr/mem_wdata stay stable from ISSUE through RELEASE.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → op=0, selFSM=0, rsp_valid=0, rsp_rdata=0 immediately. After release → cmd_ready=1 on the next edge.
- Write: cmd_we=1, addr=4'h3, wdata=8'hA5; FSM model gives fsm_valid with fsm_rw=1 two cycles after ISSUE. Expect:
  - op=1, selFSM=1 for two cycles, then op=0;
  - mem_addr=3, mem_wdata=A5;
  - rsp_valid=1, rsp_err=0 for one cycle;
  - then selFSM=0 for one cycle.
- Read: model returns mem_rdata=8'h5A with fsm_valid, fsm_rw=0 → rsp_rdata=5A, rsp_err=0; op stays 0 throughout.
- Back-to-back: write then read, cmd_valid held high → second accept exactly one cycle after RELEASE; two rsp_valid pulses, no overlap.
- Timeout: fsm_valid never asserted → rsp_valid=1, rsp_err=1 after TIMEOUT WAIT cycles (15); rsp_rdata unchanged; selFSM drops.
- Mismatch: fsm_valid=1 with fsm_rw=1 during a read → ignored. Later fsm_valid with fsm_rw=0 → normal completion.
